// File: rtl/intc_core.sv
// Machine-level interrupt controller: per-source gateways, priority/threshold
// arbitration into a registered meip request, and a claim/complete handshake.
module intc_core #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ID_W   = $clog2(N_SRC + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_SRC-1:0]          i_src,
  input  logic [N_SRC-1:0]          i_src_en,
  input  logic [N_SRC-1:0]          i_src_edge,
  input  logic [N_SRC*PRIO_W-1:0]   i_src_prio,
  input  logic [PRIO_W-1:0]         i_threshold,
  input  logic                      i_claim,
  output logic                      o_claim_valid,
  output logic [ID_W-1:0]           o_claim_id,
  input  logic                      i_complete,
  input  logic [ID_W-1:0]           i_complete_id,
  output logic                      o_meip,
  output logic [ID_W-1:0]           o_max_id
);

  localparam int unsigned PRIO_BITS = N_SRC * PRIO_W;

  logic [N_SRC-1:0]  pend;
  logic [N_SRC-1:0]  insvc;
  logic [N_SRC-1:0]  src_q;

  logic [N_SRC-1:0]  elig_c;
  logic [N_SRC-1:0]  set_c;
  logic [N_SRC-1:0]  claim_clr_c;
  logic [N_SRC-1:0]  cmp_clr_c;
  logic [N_SRC-1:0]  insvc_eff_c;
  logic [ID_W-1:0]   win_id_c;
  logic [PRIO_W-1:0] win_prio_c;
  logic [PRIO_BITS-1:0] prio_c;

  assign prio_c = i_src_prio;

  // Arbiter: strict '>' while scanning upward keeps ties on the lowest id.
  always_comb begin
    elig_c     = '0;
    win_id_c   = '0;
    win_prio_c = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      elig_c[k] = pend[k] & i_src_en[k] & (prio_c[k*PRIO_W +: PRIO_W] > i_threshold);
      if (elig_c[k] && (prio_c[k*PRIO_W +: PRIO_W] > win_prio_c)) begin
        win_id_c   = ID_W'(k + 1);
        win_prio_c = prio_c[k*PRIO_W +: PRIO_W];
      end
    end
  end

  // Gateways; a level source may re-pend in the same cycle its completion lands.
  always_comb begin
    cmp_clr_c   = '0;
    claim_clr_c = '0;
    insvc_eff_c = '0;
    set_c       = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cmp_clr_c[k]   = i_complete & (i_complete_id == ID_W'(k + 1));
      claim_clr_c[k] = i_claim & (win_id_c == ID_W'(k + 1));
      insvc_eff_c[k] = insvc[k] & ~cmp_clr_c[k];
      set_c[k]       = i_src_edge[k] ? (i_src[k] & ~src_q[k])
                                     : (i_src[k] & ~pend[k] & ~insvc_eff_c[k]);
    end
  end

  // Edge set is ORed in after the claim clear so a coincident edge survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend          <= '0;
      insvc         <= '0;
      src_q         <= '0;
      o_claim_valid <= 1'b0;
      o_claim_id    <= '0;
      o_meip        <= 1'b0;
      o_max_id      <= '0;
    end else begin
      pend          <= (pend & ~claim_clr_c) | set_c;
      insvc         <= insvc_eff_c | claim_clr_c;
      src_q         <= i_src;
      o_claim_valid <= i_claim;
      if (i_claim) begin
        o_claim_id <= win_id_c;
      end
      o_meip        <= |elig_c;
      o_max_id      <= win_id_c;
    end
  end

endmodule

// File: tb/tb_intc_core.sv
// Bench for intc_core: fixed vector table, directed corner sequences and a
// randomized run, all checked against a per-cycle reference model.
module tb_intc_core;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  src, src_en, src_edge;
  logic [N*PW-1:0] src_prio;
  logic [PW-1:0] threshold;
  logic          claim, complete;
  logic [IW-1:0] complete_id;
  logic          claim_valid, meip;
  logic [IW-1:0] claim_id, max_id;

  intc_core #(.N_SRC(N), .PRIO_W(PW), .ID_W(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_src(src), .i_src_en(src_en), .i_src_edge(src_edge),
    .i_src_prio(src_prio), .i_threshold(threshold),
    .i_claim(claim), .o_claim_valid(claim_valid), .o_claim_id(claim_id),
    .i_complete(complete), .i_complete_id(complete_id),
    .o_meip(meip), .o_max_id(max_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, indexed by source id 1..N.
  bit m_pend[1:8];
  bit m_insvc[1:8];
  bit m_srcq[1:8];
  bit m_meip, m_cv;
  int m_max, m_cid;

  typedef struct {
    logic [N-1:0]  src;
    logic          claim;
    logic          complete;
    logic [IW-1:0] cid;
    logic          e_meip;
    logic [IW-1:0] e_max;
    logic          e_cv;
    logic [IW-1:0] e_cid;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int prio_of(input int id);
    logic [N*PW-1:0] p;
    p = src_prio;
    return int'(p[(id-1)*PW +: PW]);
  endfunction

  // Highest priority eligible id; scanning downward with >= lets the lower id win ties.
  function automatic int m_winner();
    int best, bp;
    best = 0;
    bp   = 0;
    for (int k = N; k >= 1; k--) begin
      if (m_pend[k] && src_en[k-1] && prio_of(k) > int'(threshold) && prio_of(k) >= bp) begin
        best = k;
        bp   = prio_of(k);
      end
    end
    return best;
  endfunction

  task automatic m_reset();
    for (int k = 1; k <= N; k++) begin
      m_pend[k] = 0; m_insvc[k] = 0; m_srcq[k] = 0;
    end
    m_meip = 0; m_cv = 0; m_max = 0; m_cid = 0;
  endtask

  // One clock: model predicts next state from current inputs, then outputs are compared.
  task automatic step();
    int w, cid;
    bit np[1:8];
    bit ni[1:8];
    bit nq[1:8];
    bit nm;
    w   = m_winner();
    nm  = (w != 0);
    np  = m_pend;
    ni  = m_insvc;
    cid = int'(complete_id);
    if (complete && cid >= 1 && cid <= N) ni[cid] = 0;
    for (int k = 1; k <= N; k++) begin
      if (!src_edge[k-1] && src[k-1] && !m_pend[k] && !ni[k]) np[k] = 1;
      nq[k] = src[k-1];
    end
    if (claim && w != 0) begin
      np[w] = 0;
      ni[w] = 1;
    end
    for (int k = 1; k <= N; k++)
      if (src_edge[k-1] && src[k-1] && !m_srcq[k]) np[k] = 1;
    @(posedge clk);
    #1;
    m_pend = np; m_insvc = ni; m_srcq = nq;
    m_meip = nm; m_max = w; m_cv = claim;
    if (claim) m_cid = w;
    chk("model_meip", meip, m_meip);
    chk("model_max_id", max_id, m_max);
    chk("model_claim_valid", claim_valid, m_cv);
    chk("model_claim_id", claim_id, m_cid);
  endtask

  task automatic do_claim();
    claim = 1'b1; step(); claim = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete = 1'b1; complete_id = IW'(id); step(); complete = 1'b0;
  endtask

  task automatic set_prio(input int id, input int p);
    src_prio[(id-1)*PW +: PW] = PW'(p);
  endtask

  initial begin
    tbl[0]  = '{8'h04, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0};
    tbl[1]  = '{8'h04, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0};
    tbl[2]  = '{8'h04, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd3};
    tbl[3]  = '{8'h04, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3};
    tbl[4]  = '{8'h04, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd3};
    tbl[5]  = '{8'h04, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd3};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 4'd3};
    tbl[7]  = '{8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd3};
    tbl[8]  = '{8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd3};
    tbl[10] = '{8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0};

    rst_n = 1'b0; src = '0; src_en = '1; src_edge = '0; src_prio = '0;
    threshold = '0; claim = 1'b0; complete = 1'b0; complete_id = '0;
    m_reset();
    #12;
    chk("reset_meip", meip, 0);
    chk("reset_max_id", max_id, 0);
    chk("reset_claim_valid", claim_valid, 0);
    chk("reset_claim_id", claim_id, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Level basic, as a cycle table.
    set_prio(3, 2);
    for (int i = 0; i < 12; i++) begin
      src = tbl[i].src; claim = tbl[i].claim;
      complete = tbl[i].complete; complete_id = tbl[i].cid;
      step();
      claim = 1'b0; complete = 1'b0;
      chk($sformatf("tbl%0d_meip", i), meip, tbl[i].e_meip);
      chk($sformatf("tbl%0d_max_id", i), max_id, tbl[i].e_max);
      chk($sformatf("tbl%0d_claim_valid", i), claim_valid, tbl[i].e_cv);
      chk($sformatf("tbl%0d_claim_id", i), claim_id, tbl[i].e_cid);
    end

    // Priority and tie-break with back-to-back claims.
    src_prio = '0; set_prio(2, 5); set_prio(5, 5); set_prio(7, 6);
    src = 8'h52; step(); src = '0; step(); step();
    chk("prio_max_id", max_id, 7);
    do_claim(); chk("prio_claim1", claim_id, 7);
    do_claim(); chk("prio_claim2", claim_id, 2);
    do_claim(); chk("prio_claim3", claim_id, 5);
    do_claim(); chk("prio_claim4", claim_id, 0); chk("prio_claim4_valid", claim_valid, 1);
    do_complete(7); do_complete(2); do_complete(5);

    // Threshold and enable.
    src_prio = '0; set_prio(4, 3); threshold = 3'd3;
    src = 8'h08; step(); src = '0; step(); step();
    chk("thr3_meip", meip, 0);
    threshold = 3'd2; step(); chk("thr2_meip", meip, 1);
    src_en = 8'hF7; step(); chk("dis_meip", meip, 0);
    src_en = 8'hFF; step(); chk("reen_meip", meip, 1); chk("reen_max_id", max_id, 4);
    do_claim(); chk("thr_claim", claim_id, 4);
    do_complete(4); threshold = '0;

    // Edge coalescing and edge coincident with claim.
    src_prio = '0; set_prio(6, 1); src_edge = 8'h20;
    for (int i = 0; i < 3; i++) begin
      src = 8'h20; step(); src = '0; step();
    end
    step();
    do_claim(); chk("edge_claim1", claim_id, 6);
    step();
    do_claim(); chk("edge_claim2", claim_id, 0);
    do_complete(6);
    src = 8'h20; step(); src = '0; step(); step();
    src = 8'h20; do_claim(); chk("edge_coinc_claim", claim_id, 6);
    src = '0; step();
    chk("edge_coinc_meip", meip, 1); chk("edge_coinc_max_id", max_id, 6);
    do_claim(); do_complete(6); src_edge = '0;

    // Bad completes leave state alone.
    src_prio = '0; set_prio(1, 1); set_prio(2, 5); set_prio(3, 2);
    src = 8'h04; step(); step();
    do_claim(); chk("bad_setup_claim", claim_id, 3);
    src = 8'h05; step(); step();
    do_complete(0); chk("bad0_meip", meip, 1); chk("bad0_max_id", max_id, 1);
    do_complete(9); chk("bad9_meip", meip, 1); chk("bad9_max_id", max_id, 1);
    do_complete(2); chk("bad2_meip", meip, 1); chk("bad2_max_id", max_id, 1);
    do_complete(3); step(); chk("good3_max_id", max_id, 3);
    src = '0; do_claim(); do_claim(); do_complete(3); do_complete(1);

    // Reset in the cycle after a claim.
    src_prio = '0; set_prio(5, 4); src = 8'h10; step(); src = '0; step();
    do_claim(); chk("rst_pre_claim_id", claim_id, 5);
    rst_n = 1'b0; #1;
    chk("rst_mid_meip", meip, 0);
    chk("rst_mid_max_id", max_id, 0);
    chk("rst_mid_claim_valid", claim_valid, 0);
    chk("rst_mid_claim_id", claim_id, 0);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    step(); chk("rst_post_claim_valid", claim_valid, 0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        src_en    = N'($urandom);
        src_edge  = N'($urandom);
        src_prio  = (N*PW)'($urandom);
        threshold = PW'($urandom_range(0, 2));
      end
      src         = N'($urandom);
      claim       = ($urandom % 4 == 0);
      complete    = ($urandom % 3 == 0);
      complete_id = IW'($urandom_range(0, 9));
      step();
    end
    claim = 1'b0; complete = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intc_core.md
# intc_core

Parametrised machine-level interrupt controller with N external sources, per-source priority/enable/trigger mode, a threshold, and a claim/complete handshake. It replaces the single fixed-priority external/software/timer pick by arbitrating many platform sources into one registered `meip` request. That request feeds `mip.meip` in the CSR file, and from there the core's trap dispatch. The claim/complete ports are driven by the memory-mapped claim register.

## Interface
Parameters:
- `N_SRC`, default 8: number of sources, ids 1..N_SRC; id 0 means "none"; legal range 1..63.
- `PRIO_W`, default 3: priority width; priority 0 means never interrupt.
- `ID_W`, default `$clog2(N_SRC+1)`: source id width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_src`  in  N_SRC  raw source lines, already synchronous to `i_clk`; bit k-1 is id k.
- `i_src_en`  in  N_SRC  per-source enable.
- `i_src_edge`  in  N_SRC  trigger mode: 1 = rising-edge, 0 = level-high.
- `i_src_prio`  in  N_SRC*PRIO_W  priorities; slice [(k-1)*PRIO_W +: PRIO_W] is id k.
- `i_threshold`  in  PRIO_W  a source only interrupts if its priority is strictly greater than this.
- `i_claim`  in  1  one-cycle claim request.
- `o_claim_valid`  out  1  one-cycle pulse, one cycle after `i_claim`.
- `o_claim_id`  out  ID_W  claimed id, 0 if nothing was eligible; held until the next claim.
- `i_complete`  in  1  one-cycle completion strobe.
- `i_complete_id`  in  ID_W  id being completed.
- `o_meip`  out  1  registered: at least one eligible source.
- `o_max_id`  out  ID_W  registered: current winning id, 0 if none.

## Operation
- State per source:
  - `pend[k]`: pending latch.
  - `insvc[k]`: in service (claimed, not yet completed).
  - `src_q[k]`: previous `i_src`, used for edge detect.
- Eligibility:
  - `elig[k] = pend[k] & i_src_en[k] & (prio[k] > i_threshold)`.
  - Winner = eligible source with highest priority; ties go to the lowest id.
  - Winner is a combinational function of current state and config.
- Gateway, level mode:
  - `pend` sets when `i_src` = 1, `pend` = 0 and `insvc` = 0.
  - A level that drops before the claim does not clear `pend`.
- Gateway, edge mode:
  - `pend` sets on `i_src & ~src_q`, regardless of `insvc`.
  - Multiple edges before a claim coalesce into one pending.
- Disabled sources:
  - They still latch `pend` but never win.
  - Re-enabling exposes the latched request.
- Claim:
  - Latches the winner into `o_claim_id`.
  - Clears `pend[winner]` and sets `insvc[winner]`.
  - If there is no winner: `o_claim_id` = 0 and no state change.
- Complete:
  - Clears `insvc[i_complete_id]`.
  - Ignored if the id is 0, greater than N_SRC, or not in service.
- Changing `i_src_prio`, `i_src_en` or `i_threshold` takes effect on the next `o_meip`/`o_max_id` register update. It has no effect on `pend` or `insvc`.

## Timing
- Reset (asynchronous assert, synchronous-safe release): all of the following are 0:
  - `pend`, `insvc`, `src_q`;
  - `o_claim_valid`, `o_claim_id`;
  - `o_meip`, `o_max_id`.
- Latency:
  - Source asserted in cycle t: `pend` = 1 at t+1, `o_meip`/`o_max_id` valid at t+2.
  - `i_claim` in cycle t uses the winner from state at t; `o_claim_valid`/`o_claim_id` appear at t+1, with `pend`/`insvc` updated at t+1.
  - `o_meip` reflects the cleared pending at t+2.
- Back-to-back claims (t, t+1) are legal; the second claim sees the state after the first.
- Simultaneous events on the same id in one cycle:
  - Claim and edge-mode set: set wins, so `pend` stays 1 and `insvc` = 1.
  - Claim and level-mode set: clear wins, because `insvc` becomes 1.
  - Claim and complete: both apply. Complete clears `insvc` at t+1, then the claim sets it, so the net result is `insvc` = 1.
- Complete in cycle t with the level source still high: `pend` re-sets at t+1, `o_meip` at t+2.
- Reset asserted mid-handshake: any in-flight claim is discarded; no `o_claim_valid` pulse after reset release.

## Test plan
- **Level basic.** N_SRC=8, prio[3]=2, threshold=0, en=all.
  - Raise `i_src[2]` (id 3) at t: `o_meip` = 1, `o_max_id` = 3 at t+2.
  - Claim: `o_claim_id` = 3 and `o_claim_valid` = 1 one cycle later; `o_meip` = 0 two cycles after the claim.
  - Complete id 3 with the line still high: `o_meip` returns 1 two cycles later.
- **Priority and tie-break.** prio[2]=5, prio[5]=5, prio[7]=6, all pending.
  - Successive claims return 7, 2, 5, then 0 with `o_claim_valid` = 1.
- **Threshold and enable.** prio[4]=3.
  - threshold=3: `o_meip` = 0.
  - threshold=2: `o_meip` = 1 next cycle.
  - `i_src_en[3]` = 0 with threshold=2: `o_meip` = 0 and `pend` held; re-enable: `o_meip` = 1.
- **Edge coalescing.** id 6 in edge mode.
  - Three pulses before a claim produce exactly one claim of 6; the next claim returns 0.
  - A pulse on the same cycle as the claim leaves id 6 pending afterward.
- **Bad complete.** Complete ids 0, 9 and an unclaimed id 2: no state change, and `o_meip`/`o_max_id` are unchanged.
- **Reset mid-operation.** Assert `i_rst_n` = 0 the cycle after `i_claim`: all outputs are 0 immediately, and no pulse follows release.
